// File: rtl/usr_rx_pkg.sv
// Shared constants for the serial receiver: state encoding, default word width
// and the idle level of the serial line.
package usr_rx_pkg;

    localparam int unsigned RX_WIDTH_DEF = 8;
    localparam logic        LINE_IDLE    = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_e;

endpackage

// File: rtl/usr_sipo_shift.sv
// WIDTH-bit serial-in/parallel-out right-shift register.
// New bits enter at the MSB, so after WIDTH shifts bit 0 holds the first bit.
module usr_sipo_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: clear wins over shift, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (shift_i) begin
            q_d = {sin_i, q_q[WIDTH-1:1]};
        end
    end

    // Storage flops.
    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/usr_serial_receiver.sv
// Serial-in/parallel-out frame receiver with a one-word valid/ready buffer.
// Frame: start (0), WIDTH data bits LSB first, [even parity], stop (1).
// Optional parity stage is enabled by defining USR_RX_PARITY_EN.
module usr_serial_receiver
    import usr_rx_pkg::*;
#(
    parameter int unsigned WIDTH = RX_WIDTH_DEF,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             bit_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
`ifdef USR_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             busy_q;
    logic [WIDTH-1:0] sr_q;

    logic             start_c;
    logic             shift_c;
    logic             commit_c;
    logic             consume_c;

`ifdef USR_RX_PARITY_EN
    logic             par_err_q;
    logic             parity_err_q;
`endif

    // Strobe-qualified events decoded from the current state.
    always_comb begin
        start_c   = bit_en && (state_q == IDLE) && (sin != LINE_IDLE);
        shift_c   = bit_en && (state_q == DATA);
        consume_c = dout_valid_q && dout_ready;
`ifdef USR_RX_PARITY_EN
        commit_c  = bit_en && (state_q == STOP) && (sin == LINE_IDLE) && !par_err_q;
`else
        commit_c  = bit_en && (state_q == STOP) && (sin == LINE_IDLE);
`endif
    end

    // Shift register is cleared on reset and at each start bit.
    usr_sipo_shift #(
        .WIDTH (WIDTH)
    ) u_shift (
        .clk     (clk),
        .clr_i   (reset || start_c),
        .shift_i (shift_c),
        .sin_i   (sin),
        .q_o     (sr_q)
    );

    // Frame FSM; only bit_en cycles advance it. Error flags are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef USR_RX_PARITY_EN
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err_q  <= 1'b0;
`ifdef USR_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (sin != LINE_IDLE) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef USR_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
`ifdef USR_RX_PARITY_EN
                    PARITY: begin
                        // Even parity: data bits XOR parity bit must be 0.
                        par_err_q <= (^sr_q) ^ sin;
                        state_q   <= STOP;
                    end
`endif
                    STOP: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (sin != LINE_IDLE) begin
                            frame_err_q <= 1'b1;
`ifdef USR_RX_PARITY_EN
                        end else if (par_err_q) begin
                            parity_err_q <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // One-word output buffer: load on commit when empty or being consumed,
    // otherwise drop the word and latch the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (consume_c) begin
                dout_valid_q <= 1'b0;
            end
            if (commit_c) begin
                if (!dout_valid_q || dout_ready) begin
                    dout_q       <= sr_q;
                    dout_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;
`ifdef USR_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_usr_serial_receiver.sv
// Directed bench for usr_serial_receiver: table of whole-frame vectors plus
// hand-written sequences for back-pressure, slow strobes and mid-frame reset.
module tb_usr_serial_receiver;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin;
    logic       bit_en;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef USR_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
`endif

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rdy_stop;
        logic       consume;
        logic [7:0] exp_dout;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_ovr;
    } vec_t;

    vec_t vecs[5];

    usr_serial_receiver #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .bit_en     (bit_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
`ifdef USR_RX_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One strobed bit, then 'gap' non-strobe cycles with sin toggling.
    task automatic send_bit(input logic b, input int gap);
        sin    = b;
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            sin = ~sin;
            tick();
        end
        sin = 1'b1;
    endtask

    // Full frame; dout_ready is raised only for the stop-bit cycle if rdy_stop.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                              input logic rdy_stop);
        send_bit(1'b0, gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i], gap);
        end
`ifdef USR_RX_PARITY_EN
        send_bit((^d) ^ par_flip, gap);
`endif
        dout_ready = rdy_stop;
        send_bit(stop, 0);
        dout_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        sin        = 1'b1;
        bit_en     = 1'b0;
        dout_ready = 1'b0;

        //               data   stop  rdy   cons  dout   vld   ferr  ovr
        vecs[0] = '{8'h9A, 1'b1, 1'b0, 1'b1, 8'h9A, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h12, 1'b0, 1'b0, 1'b0, 8'h9A, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1};

        do_reset();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_ferr", 32'(frame_err), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Table: continuous strobes, one frame per row.
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].stop, 0, vecs[v].rdy_stop);
            chk($sformatf("v%0d_dout", v), 32'(dout), 32'(vecs[v].exp_dout));
            chk($sformatf("v%0d_valid", v), 32'(dout_valid), 32'(vecs[v].exp_valid));
            chk($sformatf("v%0d_ferr", v), 32'(frame_err), 32'(vecs[v].exp_ferr));
            chk($sformatf("v%0d_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'h0);
            dout_ready = vecs[v].consume;
            tick();
            dout_ready = 1'b0;
            chk($sformatf("v%0d_ferr_next", v), 32'(frame_err), 32'h0);
            chk($sformatf("v%0d_valid_next", v), 32'(dout_valid),
                vecs[v].consume ? 32'h0 : 32'(vecs[v].exp_valid));
        end

        // Commit coinciding with a consume: new word loads, no overrun.
        do_reset();
        send_frame(8'h01, 1'b1, 0, 1'b0);
        chk("cc_first", 32'(dout), 32'h01);
        send_frame(8'hFF, 1'b1, 0, 1'b1);
        chk("cc_dout", 32'(dout), 32'hFF);
        chk("cc_valid", 32'(dout_valid), 32'h1);
        chk("cc_ovr", 32'(overrun), 32'h0);

        // Strobe every 4th cycle with sin toggling between strobes.
        do_reset();
        send_bit(1'b0, 3);
        chk("slow_busy", 32'(busy), 32'h1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h9A;
            send_bit(w[i], 3);
        end
`ifdef USR_RX_PARITY_EN
        send_bit(1'b0, 3);
`endif
        chk("slow_valid_pre", 32'(dout_valid), 32'h0);
        send_bit(1'b1, 0);
        chk("slow_dout", 32'(dout), 32'h9A);
        chk("slow_valid", 32'(dout_valid), 32'h1);
        chk("slow_busy_end", 32'(busy), 32'h0);

        // Reset after the 4th data bit abandons the frame and empties the buffer.
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            send_bit(1'b1, 0);
        end
        chk("mid_busy_pre", 32'(busy), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", 32'(busy), 32'h0);
        chk("mid_valid", 32'(dout_valid), 32'h0);
        chk("mid_dout", 32'(dout), 32'h0);
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        chk("mid_new_dout", 32'(dout), 32'h3C);
        chk("mid_new_valid", 32'(dout_valid), 32'h1);

`ifdef USR_RX_PARITY_EN
        // Wrong parity with a good stop bit: pulse parity_err, drop the word.
        do_reset();
        par_flip = 1'b1;
        send_frame(8'h3C, 1'b1, 0, 1'b0);
        par_flip = 1'b0;
        chk("par_err", 32'(parity_err), 32'h1);
        chk("par_valid", 32'(dout_valid), 32'h0);
        chk("par_ferr", 32'(frame_err), 32'h0);
        tick();
        chk("par_err_next", 32'(parity_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
